keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_INTERVAL, default 16'd49999, giving the tick period in clocks minus one.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4'd8, giving the consecutive stable ticks needed to accept a press or release.
REQ-003 SHALL have parameter REPEAT_TICKS, default 8'd100, giving the held-key repeat period in ticks (used only under REQ-026).
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_col  input  4  keypad columns, active-low, externally pulled up, asynchronous to i_clk.
REQ-007 i_clear  input  1  synchronous clear of o_data.
REQ-008 o_row  output  4  row drive, active-low, exactly one bit low.
REQ-009 o_key_valid  output  1  one-cycle pulse per accepted key.
REQ-010 o_key_code  output  4  code of last accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-011 o_data  output  32  entered hex word; new digits shift in at bits [3:0].

Function
REQ-012 i_col SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-013 A 16-bit counter SHALL count 0..SCAN_INTERVAL and wrap; "tick" is the cycle where counter == SCAN_INTERVAL.
REQ-014 States SHALL be SCAN, DEBOUNCE, HOLD.
REQ-015 SCAN: on tick with all columns high, o_row SHALL rotate 1110->1101->1011->0111->1110.
REQ-016 SCAN: on tick with any column low, the block SHALL latch row_idx (current low row) and col_idx (lowest-index low column), freeze o_row, clear the stable count and enter DEBOUNCE.
REQ-017 DEBOUNCE: on tick, if the latched column is still low the stable count SHALL increment; otherwise the block SHALL return to SCAN and resume rotation on the next tick.
REQ-018 DEBOUNCE: when the stable count reaches DEBOUNCE_TICKS, the block SHALL in the same cycle pulse o_key_valid, load o_key_code, shift o_data <= {o_data[27:0], code}, and enter HOLD.
REQ-019 HOLD: o_row SHALL stay frozen; each tick with all columns high SHALL increment a release count, and any tick with a column low SHALL clear it.
REQ-020 HOLD: when the release count reaches DEBOUNCE_TICKS, the block SHALL enter SCAN with o_row unchanged.
REQ-021 Additional keys pressed in DEBOUNCE or HOLD SHALL be ignored (no rollover).
REQ-022 i_clear SHALL set o_data to 0 on the next edge, takes priority over a simultaneous shift, and does not suppress that cycle's o_key_valid or o_key_code update.
REQ-023 Press-to-valid latency SHALL be at most (DEBOUNCE_TICKS+5)*(SCAN_INTERVAL+1)+2 clocks after the column goes low.

Reset
REQ-024 While i_rst is high: o_row=4'b1110, o_key_valid=0, o_key_code=0, o_data=0, state=SCAN, all counters 0, synchronizer flops 4'hF.
REQ-025 Reset asserted mid-DEBOUNCE or mid-HOLD SHALL discard the pending key; after release, scanning restarts at row 0 with no o_key_valid.

Configuration
REQ-026 Macro KEYPAD_AUTOREPEAT_EN defined: in HOLD, every REPEAT_TICKS consecutive ticks with the latched column low SHALL produce a repeat of REQ-018 (pulse, code, shift), and the 8-bit repeat counter SHALL clear on any high tick.
REQ-027 Macro KEYPAD_AUTOREPEAT_EN undefined: no repeat logic exists; exactly one o_key_valid per press.

Verification (bench: SCAN_INTERVAL=3, DEBOUNCE_TICKS=2, REPEAT_TICKS=4)
REQ-028 Reset then idle columns 4'hF for 40 clocks -> o_row cycles 1110,1101,1011,0111 every 4 clocks, o_key_valid never high.
REQ-029 Hold i_col=4'b1011 while o_row=4'b1101 until accepted -> one o_key_valid, o_key_code=4'h6, o_data=32'h0000_0006.
REQ-030 Enter keys 1,2,...,9 (nine presses) -> o_data=32'h2345_6789 and first digit shifted out.
REQ-031 Column low for one tick only (bounce) -> return to SCAN, no o_key_valid, o_data unchanged.
REQ-032 Assert i_clear in the o_key_valid cycle of key 4'hA -> o_data=0 next cycle, o_key_code=4'hA.
REQ-033 KEYPAD_AUTOREPEAT_EN on, key 4'h3 held 14 ticks after acceptance -> three further pulses, o_data=32'h0000_3333; macro off -> single pulse, o_data=32'h0000_0003.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner. Rotates one low row
// per scan tick, debounces a press and its release over DEBOUNCE_TICKS ticks,
// reports each accepted key as a one-cycle pulse plus code, and shifts the
// code into a 32-bit hex entry word.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to repeat a held key every
// REPEAT_TICKS ticks; without it each press yields exactly one pulse.
module keypad_scanner #(
  parameter logic [15:0] SCAN_INTERVAL  = 16'd49999,
  parameter logic [3:0]  DEBOUNCE_TICKS = 4'd8,
  parameter logic [7:0]  REPEAT_TICKS   = 8'd100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_col,
  input  logic        i_clear,
  output logic [3:0]  o_row,
  output logic        o_key_valid,
  output logic [3:0]  o_key_code,
  output logic [31:0] o_data
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  col_p0, col_p1;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [3:0]  row_nxt;
  logic [1:0]  row_idx, row_idx_nxt;
  logic [1:0]  col_idx, col_idx_nxt;
  logic [3:0]  stab_cnt, stab_nxt;
  logic [3:0]  rel_cnt, rel_nxt;
  logic        accept;
  logic        any_low;
  logic        key_low;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [7:0]  rpt_cnt, rpt_nxt;
`else
  logic        unused_repeat;
  assign unused_repeat = ^REPEAT_TICKS;
`endif

  // Index of the lowest-numbered 0 bit; used for both rows and columns.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  assign tick    = (tick_cnt == SCAN_INTERVAL);
  assign any_low = ~&col_p1;
  assign key_low = ~col_p1[col_idx];

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_p0 <= 4'hF;
      col_p1 <= 4'hF;
    end else begin
      col_p0 <= i_col;
      col_p1 <= col_p0;
    end
  end

  // Free-running scan tick divider, wraps after SCAN_INTERVAL.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tick_cnt <= 16'd0;
    else       tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
  end

  // FSM and scan control registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= SCAN;
      o_row    <= 4'b1110;
      row_idx  <= 2'd0;
      col_idx  <= 2'd0;
      stab_cnt <= 4'd0;
      rel_cnt  <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt  <= 8'd0;
`endif
    end else begin
      state    <= state_nxt;
      o_row    <= row_nxt;
      row_idx  <= row_idx_nxt;
      col_idx  <= col_idx_nxt;
      stab_cnt <= stab_nxt;
      rel_cnt  <= rel_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt  <= rpt_nxt;
`endif
    end
  end

  // Next-state logic: everything advances only on a scan tick.
  always_comb begin
    state_nxt   = state;
    row_nxt     = o_row;
    row_idx_nxt = row_idx;
    col_idx_nxt = col_idx;
    stab_nxt    = stab_cnt;
    rel_nxt     = rel_cnt;
    accept      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_nxt     = rpt_cnt;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            row_idx_nxt = low_index(o_row);
            col_idx_nxt = low_index(col_p1);
            stab_nxt    = 4'd0;
            state_nxt   = DEBOUNCE;
          end else begin
            row_nxt = {o_row[2:0], o_row[3]};
          end
        end
        DEBOUNCE: begin
          if (key_low) begin
            stab_nxt = stab_cnt + 4'd1;
            if (({1'b0, stab_cnt} + 5'd1) >= {1'b0, DEBOUNCE_TICKS}) begin
              accept    = 1'b1;
              rel_nxt   = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_nxt   = 8'd0;
`endif
              state_nxt = HOLD;
            end
          end else begin
            state_nxt = SCAN;
          end
        end
        HOLD: begin
          if (any_low) begin
            rel_nxt = 4'd0;
          end else begin
            rel_nxt = rel_cnt + 4'd1;
            if (({1'b0, rel_cnt} + 5'd1) >= {1'b0, DEBOUNCE_TICKS}) begin
              rel_nxt   = 4'd0;
              state_nxt = SCAN;
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (key_low) begin
            rpt_nxt = rpt_cnt + 8'd1;
            if (({1'b0, rpt_cnt} + 9'd1) >= {1'b0, REPEAT_TICKS}) begin
              rpt_nxt = 8'd0;
              accept  = 1'b1;
            end
          end else begin
            rpt_nxt = 8'd0;
          end
`endif
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // Key report and hex entry word; clear wins over a same-cycle shift.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_key_valid <= 1'b0;
      o_key_code  <= 4'd0;
      o_data      <= 32'd0;
    end else begin
      o_key_valid <= accept;
      if (accept) o_key_code <= {row_idx, col_idx};
      if (i_clear)     o_data <= 32'd0;
      else if (accept) o_data <= {o_data[27:0], row_idx, col_idx};
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench with a keypad matrix model and a
// scoreboard; expected key reports are queued by the stimulus and checked by
// an independent monitor whenever o_key_valid pulses.
module tb_keypad_scanner;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_col;
  logic        i_clear = 1'b0;
  logic [3:0]  o_row;
  logic        o_key_valid;
  logic [3:0]  o_key_code;
  logic [31:0] o_data;

  logic        key_down = 1'b0;
  logic [1:0]  key_r = 2'd0;
  logic [1:0]  key_c = 2'd0;
  logic [3:0]  force_col = 4'hF;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_data = 32'd0;
  int          checks = 0;
  int          errors = 0;

  keypad_scanner #(
    .SCAN_INTERVAL (16'd3),
    .DEBOUNCE_TICKS(4'd2),
    .REPEAT_TICKS  (8'd4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_col      (i_col),
    .i_clear    (i_clear),
    .o_row      (o_row),
    .o_key_valid(o_key_valid),
    .o_key_code (o_key_code),
    .o_data     (o_data)
  );

  always #5 i_clk = ~i_clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    logic [3:0] kp;
    kp = 4'hF;
    if (key_down && !o_row[key_r]) kp[key_c] = 1'b0;
    i_col = kp & force_col;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] row_pat(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  task automatic expect_key(input logic [3:0] code);
    exp_t e;
    model_data = {model_data[27:0], code};
    e.code = code;
    e.data = model_data;
    exp_q.push_back(e);
  endtask

  // Press a key, wait for acceptance, optionally clear in the valid cycle,
  // keep holding for extra_hold clocks, then release and let it settle.
  task automatic press(input logic [3:0] code, input int extra_hold, input bit do_clear);
    bit got;
    key_r = code[3:2];
    key_c = code[1:0];
    key_down = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge i_clk);
      if (o_key_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL press_timeout: key %h got no valid in 200 clocks, expected one", code);
    end
    if (got && do_clear) begin
      i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      model_data = 32'd0;
      check("clear_data", o_data, 32'd0);
      check("clear_code", {28'd0, o_key_code}, {28'd0, code});
    end
    repeat (extra_hold) @(negedge i_clk);
    key_down = 1'b0;
    repeat (30) @(negedge i_clk);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge i_clk) begin
    if (!i_rst && o_key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: code %h data %h, expected no key", o_key_code, o_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("key_code", {28'd0, o_key_code}, {28'd0, e.code});
        check("key_data", o_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r0;

    // Reset values.
    repeat (3) @(negedge i_clk);
    check("rst_row", {28'd0, o_row}, {28'd0, 4'b1110});
    check("rst_valid", {31'd0, o_key_valid}, 32'd0);
    check("rst_code", {28'd0, o_key_code}, 32'd0);
    check("rst_data", o_data, 32'd0);
    i_rst = 1'b0;

    // Idle rotation: one row step every 4 clocks.
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      check("idle_row", {28'd0, o_row}, {28'd0, row_pat((k / 4) % 4)});
    end

    // Single key: row 1, column 2.
    expect_key(4'h6);
    press(4'h6, 0, 1'b0);
    check("key6_data", o_data, 32'h0000_0006);

    // Nine digits shift the first digit out of the word.
    for (int n = 1; n <= 9; n++) begin
      expect_key(4'(n));
      press(4'(n), 0, 1'b0);
    end
    check("digits_data", o_data, 32'h2345_6789);

    // Bounce: column low across exactly one tick right after a row step.
    r0 = o_row;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_row != r0) break;
    end
    force_col = 4'b1110;
    repeat (4) @(negedge i_clk);
    force_col = 4'hF;
    repeat (30) @(negedge i_clk);
    check("bounce_data", o_data, 32'h2345_6789);
    r0 = o_row;
    repeat (4) @(negedge i_clk);
    check("bounce_rotates", {31'd0, (o_row != r0)}, 32'd1);

    // Clear in the valid cycle of key A.
    expect_key(4'hA);
    press(4'hA, 0, 1'b1);
    check("after_clear", o_data, 32'd0);

    // Key 3 held for 14 ticks after acceptance.
    expect_key(4'h3);
`ifdef KEYPAD_AUTOREPEAT_EN
    expect_key(4'h3);
    expect_key(4'h3);
    expect_key(4'h3);
`endif
    press(4'h3, 54, 1'b0);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("held_data", o_data, 32'h0000_3333);
`else
    check("held_data", o_data, 32'h0000_0003);
`endif

    // Reset while a key is being debounced discards it.
    key_r = 2'd0;
    key_c = 2'd0;
    key_down = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_row == 4'b1110) break;
    end
    repeat (6) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("midrst_row", {28'd0, o_row}, {28'd0, 4'b1110});
    check("midrst_valid", {31'd0, o_key_valid}, 32'd0);
    check("midrst_code", {28'd0, o_key_code}, 32'd0);
    check("midrst_data", o_data, 32'd0);
    key_down = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    model_data = 32'd0;
    repeat (40) @(negedge i_clk);
    check("postrst_data", o_data, 32'd0);

    check("pending_keys", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
